// File: rtl/instr_mem_loader.sv
// Instruction memory loader: receives a length-prefixed, checksummed byte stream
// and writes it into instruction memory. The CPU is held in reset until a load succeeds.
module instr_mem_loader #(
   parameter int MEM_WORDS = 32,
   parameter int LEN_W     = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        cpu_hold
);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CHECK,
      DONE,
      ERR
   } state_t;

   localparam logic [8:0] MAX_N = 9'(MEM_WORDS);

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  word_idx;
   logic [1:0]        byte_idx;
   logic [7:0]        csum;
   logic [23:0]       shreg;

   logic              accept;
   logic              len_ok;
   logic              last_word;
   logic [31:0]       word_addr;

   assign byte_ready = (state == LEN) ||
                       (state == DATA) ||
                       (state == CHECK);

   assign accept    = byte_valid && byte_ready;
   assign len_ok    = (byte_in != 8'd0) &&
                      ({1'b0, byte_in} <= MAX_N);
   assign last_word = (word_idx == len_q - LEN_W'(1));
   assign word_addr = 32'({word_idx, 2'b00});

   // Status flags per state: {busy, done, error, cpu_hold}
   function automatic logic [3:0] flags(input state_t s);
      logic [3:0] f;
      f = 4'b0001;
      unique case (s)
         LEN, DATA, CHECK: f = 4'b1001;
         DONE:             f = 4'b0100;
         ERR:              f = 4'b0011;
         default:          f = 4'b0001;
      endcase
      return f;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         len_q     <= '0;
         word_idx  <= '0;
         byte_idx  <= '0;
         csum      <= '0;
         shreg     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         {busy, done, error, cpu_hold} <= flags(IDLE);
      end else begin
         mem_we <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= LEN;
                  {busy, done, error, cpu_hold} <= flags(LEN);
               end
            end
            LEN: begin
               if (accept) begin
                  if (!len_ok) begin
                     state <= ERR;
                     {busy, done, error, cpu_hold} <= flags(ERR);
                  end else begin
                     len_q    <= LEN_W'(byte_in);
                     word_idx <= '0;
                     byte_idx <= '0;
                     csum     <= '0;
                     state    <= DATA;
                     {busy, done, error, cpu_hold} <= flags(DATA);
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  csum     <= csum ^ byte_in;
                  shreg    <= {shreg[15:0], byte_in};
                  byte_idx <= byte_idx + 2'd1;
                  // Word complete: the write goes out next cycle, stream keeps flowing
                  if (byte_idx == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= word_addr;
                     mem_wdata <= {shreg, byte_in};
                     word_idx  <= word_idx + LEN_W'(1);
                     if (last_word) begin
                        state <= CHECK;
                        {busy, done, error, cpu_hold} <= flags(CHECK);
                     end
                  end
               end
            end
            CHECK: begin
               if (accept) begin
                  if (byte_in == csum) begin
                     state <= DONE;
                     {busy, done, error, cpu_hold} <= flags(DONE);
                  end else begin
                     state <= ERR;
                     {busy, done, error, cpu_hold} <= flags(ERR);
                  end
               end
            end
            DONE, ERR: begin
               if (start) begin
                  state <= LEN;
                  {busy, done, error, cpu_hold} <= flags(LEN);
               end
            end
            default: begin
               state <= IDLE;
               {busy, done, error, cpu_hold} <= flags(IDLE);
            end
         endcase
      end
   end

endmodule
